// File: rtl/input_streamer.sv
// ----------------------------------------------------------------------------
// input_streamer
//
// Upstream pixel feeder for the 2x upscaling output stage. A source BMP pixel
// array (24-bit BGR, bottom row first, as stored in a BMP file) is held in an
// internal ROM. The frame is streamed top row first, left to right, one pixel
// per clock. A programmable start delay precedes the first pixel and a
// programmable horizontal blank separates rows.
//
// Parameters
//   INFILE       image name, WIDTH*HEIGHT*3 bytes; ROM contents are supplied
//                from outside the module (e.g. a backdoor)
//   WIDTH        pixels per row (>= 1)
//   HEIGHT       rows per frame (>= 1)
//   START_DELAY  idle cycles between accepted start and first pixel (>= 0)
//   HBLANK       horizontal_sync-low cycles between rows (>= 0)
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   start            in   level-sampled; starts a frame from IDLE or DONE
//   horizontal_sync  out  pixel-valid strobe; r/g/b meaningful only while 1
//   r, g, b          out  8-bit colour channels, 0 outside active video
//   frame_done       out  one-cycle pulse the cycle after the last pixel
//
// Build option
//   INPUT_STREAMER_GRAY_EN  when defined, r/g/b all carry the luma
//                           y = (r + 2*g + b) >> 2; timing is unchanged.
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | after reset; waiting for start
//   S_DELAY  | counting down START_DELAY cycles before the first pixel
//   S_ACTIVE | presenting pixel (row, col); horizontal_sync high next cycle
//   S_BLANK  | counting down HBLANK cycles between rows
//   S_DONE   | frame complete; start begins a new frame
// ----------------------------------------------------------------------------
module input_streamer #(
    parameter string INFILE      = "input.hex",
    parameter int    WIDTH       = 768,
    parameter int    HEIGHT      = 512,
    parameter int    START_DELAY = 100,
    parameter int    HBLANK      = 160
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       horizontal_sync,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       frame_done
);

    localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CNT_MAX = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int MEM_D   = WIDTH * HEIGHT * 3;
    localparam int ADDR_W  = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_START  = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] CNT_HBLANK = CNT_W'(HBLANK);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_ACTIVE = 3'd2,
        S_BLANK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Pixel ROM
    // ------------------------------------------------------------------
    logic [7:0] mem [0:MEM_D-1];

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_px_q, last_px_d;

    // Registered outputs
    logic             hs_q, hs_d;
    logic [7:0]       r_q, r_d;
    logic [7:0]       g_q, g_d;
    logic [7:0]       b_q, b_d;
    logic             frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        last_px_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    row_d = '0;
                    col_d = '0;
                    if (START_DELAY == 0) begin
                        state_d = S_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = CNT_START;
                    end
                end
            end

            S_DELAY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end

            S_ACTIVE: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d   = S_DONE;
                        // frame_done follows one cycle later so it lands
                        // after the last pixel has left the output register
                        last_px_d = 1'b1;
                    end else if (HBLANK == 0) begin
                        // back-to-back rows: sync never drops
                        row_d = row_q + ROW_ONE;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = CNT_HBLANK;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end

            S_BLANK: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_ACTIVE;
                    row_d   = row_q + ROW_ONE;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel fetch: the image is stored bottom row first, so the streamed
    // row index is flipped before forming the byte address.
    // ------------------------------------------------------------------
    logic [31:0]       row_flip;
    logic [31:0]       addr;
    logic              addr_ok;
    logic [ADDR_W-1:0] idx_b, idx_g, idx_r;
    logic [7:0]        pix_r, pix_g, pix_b;

    always_comb begin
        row_flip = 32'(HEIGHT - 1) - 32'(row_q);
        addr     = 32'd3 * (32'(WIDTH) * row_flip + 32'(col_q));
        addr_ok  = (addr <= 32'(MEM_D - 3));
        idx_b    = ADDR_W'(addr);
        idx_g    = ADDR_W'(addr + 32'd1);
        idx_r    = ADDR_W'(addr + 32'd2);
        pix_b    = addr_ok ? mem[idx_b] : 8'h00;
        pix_g    = addr_ok ? mem[idx_g] : 8'h00;
        pix_r    = addr_ok ? mem[idx_r] : 8'h00;
    end

`ifdef INPUT_STREAMER_GRAY_EN
    logic [9:0] gray_sum;
    logic [7:0] gray_y;
    logic       gray_lsb_unused;

    // 10 bits hold the worst case 255 + 510 + 255 = 1020
    assign gray_sum        = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
    assign gray_y          = gray_sum[9:2];
    assign gray_lsb_unused = ^gray_sum[1:0];
`endif

    // ------------------------------------------------------------------
    // Output next-values
    // ------------------------------------------------------------------
    always_comb begin
        hs_d         = 1'b0;
        r_d          = 8'h00;
        g_d          = 8'h00;
        b_d          = 8'h00;
        frame_done_d = last_px_q;

        if (state_q == S_ACTIVE) begin
            hs_d = 1'b1;
`ifdef INPUT_STREAMER_GRAY_EN
            r_d  = gray_y;
            g_d  = gray_y;
            b_d  = gray_y;
`else
            r_d  = pix_r;
            g_d  = pix_g;
            b_d  = pix_b;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            last_px_q    <= 1'b0;
            hs_q         <= 1'b0;
            r_q          <= 8'h00;
            g_q          <= 8'h00;
            b_q          <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            last_px_q    <= last_px_d;
            hs_q         <= hs_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign horizontal_sync = hs_q;
    assign r               = r_q;
    assign g               = g_q;
    assign b               = b_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_input_streamer.sv
// ----------------------------------------------------------------------------
// tb_input_streamer
//
// Two instances on one clock and reset:
//   dut_a  WIDTH=4 HEIGHT=2 START_DELAY=3 HBLANK=2
//   dut_b  WIDTH=4 HEIGHT=2 START_DELAY=0 HBLANK=0
// The ROMs are filled by backdoor writes. Stimulus pushes the expected pixel
// stream (value and arrival cycle) and frame_done cycles into queues; a
// monitor branch pops and compares at every falling edge.
// ----------------------------------------------------------------------------
module tb_input_streamer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] rgb;
    } exp_t;

    // Expected raw {r,g,b} streams, top row first, written out by hand from
    // the ROM contents loaded below.
    localparam logic [23:0] STREAM [2][8] = '{
        '{24'h302010, 24'h312111, 24'h322212, 24'h332313,
          24'h605040, 24'h615141, 24'h625242, 24'h635343},
        '{24'hC86428, 24'hFFFFFF, 24'h030201, 24'h7F0080,
          24'h0C0B0A, 24'h0D0C0B, 24'h0E0D0C, 24'h0F0E0D}
    };

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;

    logic       hs_a, fd_a, hs_b, fd_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_start;
    logic [4:0] ai;

    exp_t       q_pix [2][$];
    int         q_done [2][$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    input_streamer #(
        .INFILE(""), .WIDTH(4), .HEIGHT(2), .START_DELAY(3), .HBLANK(2)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .horizontal_sync(hs_a), .r(r_a), .g(g_a), .b(b_a), .frame_done(fd_a)
    );

    input_streamer #(
        .INFILE(""), .WIDTH(4), .HEIGHT(2), .START_DELAY(0), .HBLANK(0)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .horizontal_sync(hs_b), .r(r_b), .g(g_b), .b(b_b), .frame_done(fd_b)
    );

    function automatic logic [23:0] model_px(input logic [23:0] rgb);
`ifdef INPUT_STREAMER_GRAY_EN
        int y;
        y = (32'(rgb[23:16]) + 2 * 32'(rgb[15:8]) + 32'(rgb[7:0])) >> 2;
        return {3{y[7:0]}};
`else
        return rgb;
`endif
    endfunction

    // npix < 8 models an aborted frame: no frame_done is expected.
    task automatic push_frame(input int d, input int n, input int sd, input int hb, input int npix);
        exp_t e;
        for (int k = 0; k < npix; k++) begin
            e.cyc = 32'(n + sd + 1 + (k / 4) * (4 + hb) + (k % 4));
            e.rgb = model_px(STREAM[d][k]);
            q_pix[d].push_back(e);
        end
        if (npix == 8) q_done[d].push_back(n + sd + 1 + 8 + hb);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic hs, input logic [23:0] rgb, input logic fd);
        exp_t e;
        int   dc;
        n_cmp++;
        if (hs) begin
            if (q_pix[d].size() == 0) begin
                n_bad++;
                $display("FAIL dut%0d_pixel_extra: got rgb %06h at cycle %0d, want none", d, rgb, cyc);
            end else begin
                e = q_pix[d].pop_front();
                if (e.cyc != 32'(cyc) || e.rgb != rgb) begin
                    n_bad++;
                    $display("FAIL dut%0d_pixel: got rgb %06h at cycle %0d, want rgb %06h at cycle %0d",
                             d, rgb, cyc, e.rgb, e.cyc);
                end
            end
        end else if (rgb != 24'h0) begin
            n_bad++;
            $display("FAIL dut%0d_idle_rgb: got %06h at cycle %0d, want 000000", d, rgb, cyc);
        end
        if (fd) begin
            n_cmp++;
            if (q_done[d].size() == 0) begin
                n_bad++;
                $display("FAIL dut%0d_frame_done_extra: got pulse at cycle %0d, want none", d, cyc);
            end else begin
                dc = q_done[d].pop_front();
                if (dc != cyc) begin
                    n_bad++;
                    $display("FAIL dut%0d_frame_done: got cycle %0d, want cycle %0d", d, cyc, dc);
                end
            end
        end
    endtask

    initial begin
        // ROM A: top row (bytes 12..23) b,g,r = 10/20/30 + col,
        //        bottom row (bytes 0..11) b,g,r = 40/50/60 + col
        for (int c = 0; c < 4; c++) begin
            ai = 5'(12 + 3 * c);
            dut_a.mem[ai]      = 8'(8'h10 + c);
            dut_a.mem[ai + 1]  = 8'(8'h20 + c);
            dut_a.mem[ai + 2]  = 8'(8'h30 + c);
            ai = 5'(3 * c);
            dut_a.mem[ai]      = 8'(8'h40 + c);
            dut_a.mem[ai + 1]  = 8'(8'h50 + c);
            dut_a.mem[ai + 2]  = 8'(8'h60 + c);
            dut_b.mem[ai]      = 8'(8'h0A + c);
            dut_b.mem[ai + 1]  = 8'(8'h0B + c);
            dut_b.mem[ai + 2]  = 8'(8'h0C + c);
        end
        // ROM B top row: (40,100,200), white, (01,02,03), (80,00,7F) as b,g,r
        dut_b.mem[12] = 8'h28; dut_b.mem[13] = 8'h64; dut_b.mem[14] = 8'hC8;
        dut_b.mem[15] = 8'hFF; dut_b.mem[16] = 8'hFF; dut_b.mem[17] = 8'hFF;
        dut_b.mem[18] = 8'h01; dut_b.mem[19] = 8'h02; dut_b.mem[20] = 8'h03;
        dut_b.mem[21] = 8'h80; dut_b.mem[22] = 8'h00; dut_b.mem[23] = 8'h7F;

        fork
            begin
                forever begin
                    @(negedge clock);
                    mon(0, hs_a, {r_a, g_a, b_a}, fd_a);
                    mon(1, hs_b, {r_b, g_b, b_b}, fd_b);
                end
            end
            begin
                // Reset held with start high: everything must stay quiet.
                start_a = 1'b1;
                #1 reset = 1'b0;
                repeat (3) @(negedge clock);
                check("rst_hs_a", 32'(hs_a), 32'd0);
                check("rst_rgb_a", 32'({r_a, g_a, b_a}), 32'd0);
                check("rst_done_a", 32'(fd_a), 32'd0);
                check("rst_hs_b", 32'(hs_b), 32'd0);

                // Release with start still high: the first edge samples it.
                #1 reset = 1'b1;
                n_start = cyc + 1;
                push_frame(0, n_start, 3, 2, 8);
                @(negedge clock);
                start_a = 1'b0;
                repeat (20) @(negedge clock);

                // Single start pulse from DONE.
                start_a = 1'b1;
                n_start = cyc + 1;
                push_frame(0, n_start, 3, 2, 8);
                @(negedge clock);
                start_a = 1'b0;
                repeat (20) @(negedge clock);

                // No delay, no blank; start held over the end of the first
                // frame restarts straight from DONE.
                start_b = 1'b1;
                n_start = cyc + 1;
                push_frame(1, n_start, 0, 0, 8);
                push_frame(1, n_start + 9, 0, 0, 8);
                repeat (10) @(negedge clock);
                start_b = 1'b0;
                repeat (20) @(negedge clock);

                // Abort while the second pixel of row 1 is on the outputs.
                start_a = 1'b1;
                n_start = cyc + 1;
                push_frame(0, n_start, 3, 2, 6);
                @(negedge clock);
                start_a = 1'b0;
                repeat (11) @(negedge clock);
                #1 reset = 1'b0;
                #1;
                check("abort_hs_a", 32'(hs_a), 32'd0);
                check("abort_rgb_a", 32'({r_a, g_a, b_a}), 32'd0);
                check("abort_done_a", 32'(fd_a), 32'd0);
                check("abort_pixels_seen_a", 32'(q_pix[0].size()), 32'd0);
                repeat (2) @(negedge clock);
                #1 reset = 1'b1;
                repeat (12) @(negedge clock);

                // Full replay from row 0; start kept high well into the frame
                // and must be ignored there.
                start_a = 1'b1;
                n_start = cyc + 1;
                push_frame(0, n_start, 3, 2, 8);
                repeat (11) @(negedge clock);
                start_a = 1'b0;
                repeat (25) @(negedge clock);

                check("pix_left_a", 32'(q_pix[0].size()), 32'd0);
                check("pix_left_b", 32'(q_pix[1].size()), 32'd0);
                check("done_left_a", 32'(q_done[0].size()), 32'd0);
                check("done_left_b", 32'(q_done[1].size()), 32'd0);
            end
        join_any

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
